// File: rtl/nanov_spi_fetch.sv
// rtl/nanov_spi_fetch.sv - SPI flash instruction fetch with 2-entry prefetch FIFO.
// Define FAST_READ_EN to use FAST READ (0x0B) with 8 dummy cycles instead of READ (0x03).
module nanov_spi_fetch #(
    parameter int          ADDR_BITS      = 22,
    parameter int unsigned RESET_ADDR     = 0,
    parameter int          CS_HIGH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 spi_select,
    output logic                 spi_out,
    input  logic                 spi_in,
    input  logic                 jump,
    input  logic [ADDR_BITS-1:0] jump_addr,
    input  logic                 instr_ready,
    output logic                 instr_valid,
    output logic [31:0]          instr_data,
    output logic [ADDR_BITS-1:0] instr_pc
);

    typedef enum logic [2:0] {
        ST_GAP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_WAIT
    } state_e;

`ifdef FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = 8'h03;
`endif

    localparam int CNT_W = ($clog2(CS_HIGH_CYCLES + 1) > 5) ? $clog2(CS_HIGH_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0]     GAP_LAST = CNT_W'(CS_HIGH_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] RST_ADDR = ADDR_BITS'(RESET_ADDR);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            shift_q, shift_d;
    logic [1:0]             count_q, count_d;
    logic [31:0]            head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [ADDR_BITS-1:0]   head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;

    logic                   push;
    logic                   pop;
    logic [31:0]            word_cur;
    logic [4:0]             bit_idx;
    logic [23:0]            flash_addr;
    logic [1:0]             occ_after;
    logic                   last_word;

    assign instr_valid = (count_q != 2'd0);
    assign instr_data  = head_data_q;
    assign instr_pc    = head_pc_q;
    assign pop         = instr_valid && instr_ready;
    assign flash_addr  = 24'(addr_q);
    assign last_word   = (addr_q[ADDR_BITS-1:2] == '1);
    assign occ_after   = count_q + 2'd1 - {1'b0, pop};

    // Bytes arrive MSB first but are stored little-endian: bit b lands at [8*(b/8) + 7-(b%8)].
    assign bit_idx = {cnt_q[4:3], ~cnt_q[2:0]};

    always_comb begin
        word_cur          = shift_q;
        word_cur[bit_idx] = spi_in;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        addr_d     = addr_q;
        shift_d    = shift_q;
        push       = 1'b0;
        spi_select = 1'b1;
        spi_out    = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                spi_select = 1'b0;
                spi_out    = OPCODE[3'd7 - cnt_q[2:0]];
                if (cnt_q == CNT_W'(7)) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                spi_select = 1'b0;
                spi_out    = flash_addr[5'd23 - cnt_q[4:0]];
                if (cnt_q == CNT_W'(23)) begin
`ifdef FAST_READ_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_DATA;
`endif
                    cnt_d   = '0;
                end
            end
            ST_DUMMY: begin
                spi_select = 1'b0;
                if (cnt_q == CNT_W'(7)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                spi_select = 1'b0;
                shift_d    = word_cur;
                if (cnt_q == CNT_W'(31)) begin
                    push   = 1'b1;
                    cnt_d  = '0;
                    addr_d = addr_q + ADDR_BITS'(4);
                    // A full FIFO takes priority: WAIT drops into GAP once space frees anyway.
                    if (occ_after == 2'd2) begin
                        state_d = ST_WAIT;
                    end else if (last_word) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = '0;
                if (count_q <= 2'd1) begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase

        if (jump) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            addr_d  = jump_addr & ~ADDR_BITS'(3);
            push    = 1'b0;
        end
    end

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        tail_data_d = tail_data_q;
        tail_pc_d   = tail_pc_q;

        if (jump) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = word_cur;
                        head_pc_d   = addr_q;
                    end else begin
                        tail_data_d = word_cur;
                        tail_pc_d   = addr_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_data_d = word_cur;
                        head_pc_d   = addr_q;
                    end else begin
                        head_data_d = tail_data_q;
                        head_pc_d   = tail_pc_q;
                        tail_data_d = word_cur;
                        tail_pc_d   = addr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_GAP;
            cnt_q       <= '0;
            addr_q      <= RST_ADDR;
            shift_q     <= '0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            tail_data_q <= '0;
            tail_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
            tail_data_q <= tail_data_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// tb/tb_nanov_spi_fetch.sv - directed bench for nanov_spi_fetch with a behavioural SPI flash.
module tb_nanov_spi_fetch;

    localparam int AB = 22;
`ifdef FAST_READ_EN
    localparam int         DSTART = 40;
    localparam logic [7:0] OPC    = 8'h0B;
`else
    localparam int         DSTART = 32;
    localparam logic [7:0] OPC    = 8'h03;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          spi_select;
    logic          spi_out;
    logic          spi_in;
    logic          jump;
    logic [AB-1:0] jump_addr;
    logic          instr_ready;
    logic          instr_valid;
    logic [31:0]   instr_data;
    logic [AB-1:0] instr_pc;

    nanov_spi_fetch #(
        .ADDR_BITS      (AB),
        .RESET_ADDR     (0),
        .CS_HIGH_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_select  (spi_select),
        .spi_out     (spi_out),
        .spi_in      (spi_in),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'd0:        return 8'h13;
            24'd1:        return 8'h05;
            24'd2, 24'd3: return 8'h00;
            default:      return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash model: samples MOSI and drives MISO on the falling edge of each selected cycle.
    int          fn = 0;
    int          txn_cnt = 0;
    logic [7:0]  sh_cmd, f_cmd;
    logic [23:0] sh_addr, f_addr;

    always @(negedge clk) begin
        if (spi_select !== 1'b0) begin
            fn     = 0;
            spi_in = 1'b0;
        end else begin
            if (fn < 8) sh_cmd = {sh_cmd[6:0], spi_out};
            else if (fn < 32) sh_addr = {sh_addr[22:0], spi_out};
            if (fn == 31) begin
                f_cmd  = sh_cmd;
                f_addr = sh_addr;
                txn_cnt++;
            end
            if (fn >= DSTART) begin
                int j;
                logic [7:0] b;
                j      = fn - DSTART;
                b      = fbyte(f_addr + 24'(j / 8));
                spi_in = b[7 - (j % 8)];
            end
            fn++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (instr_valid !== 1'b1 && k < 400) begin
            step();
            k++;
        end
        if (instr_valid !== 1'b1) check({tag, "_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_txn(input int cnt0, input string tag);
        int k;
        k = 0;
        while (txn_cnt <= cnt0 && k < 400) begin
            step();
            k++;
        end
        if (txn_cnt <= cnt0) check({tag, "_timeout"}, 32'(txn_cnt), 32'(cnt0 + 1));
    endtask

    initial begin
        int t;
        int k;
        rstn        = 1'b0;
        jump        = 1'b0;
        jump_addr   = '0;
        instr_ready = 1'b0;
        repeat (3) step();

        check("rst_select", 32'(spi_select), 32'd1);
        check("rst_spi_out", 32'(spi_out), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);

        instr_ready = 1'b1;
        rstn        = 1'b1;

        wait_txn(0, "txn0");
        check("txn0_cmd", 32'(f_cmd), 32'(OPC));
        check("txn0_addr", 32'(f_addr), 32'h0);
        wait_valid("w0");
        check("w0_n", 32'(fn), 32'(DSTART + 32));
        check("w0_data", instr_data, 32'h0000_0513);
        check("w0_pc", 32'(instr_pc), 32'h0);

        for (int i = 1; i < 4; i++) begin
            step();
            wait_valid("wseq");
            check("wseq_pc", 32'(instr_pc), 32'(4 * i));
            check("wseq_data", instr_data, word_at(24'(4 * i)));
            check("wseq_n", 32'(fn), 32'(DSTART + 32 + 32 * i));
            check("wseq_select", 32'(spi_select), 32'd0);
        end

        step();
        instr_ready = 1'b0;
        k = 0;
        while (spi_select === 1'b0 && k < 200) begin
            step();
            k++;
        end
        check("full_sel_n", 32'(fn), 32'(DSTART + 192));
        check("full_select", 32'(spi_select), 32'd1);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_pc", 32'(instr_pc), 32'd16);
        check("full_data", instr_data, word_at(24'd16));
        repeat (5) step();
        check("hold_select", 32'(spi_select), 32'd1);
        check("hold_pc", 32'(instr_pc), 32'd16);

        t = txn_cnt;
        instr_ready = 1'b1;
        step();
        check("pop2_valid", 32'(instr_valid), 32'd1);
        check("pop2_pc", 32'(instr_pc), 32'd20);
        check("pop2_data", instr_data, word_at(24'd20));
        step();
        instr_ready = 1'b0;
        wait_txn(t, "restart");
        check("restart_addr", 32'(f_addr), 32'h18);
        wait_valid("w24");
        check("w24_pc", 32'(instr_pc), 32'd24);
        check("w24_data", instr_data, word_at(24'd24));
        repeat (10) step();
        check("w24_stable_pc", 32'(instr_pc), 32'd24);
        check("w24_stable_valid", 32'(instr_valid), 32'd1);

        t = txn_cnt;
        jump_addr = 22'h001236;
        jump = 1'b1;
        step();
        jump = 1'b0;
        check("jump_valid", 32'(instr_valid), 32'd0);
        check("jump_select", 32'(spi_select), 32'd1);
        instr_ready = 1'b1;
        wait_txn(t, "jtxn");
        check("jump_addr", 32'(f_addr), 32'h001234);
        wait_valid("wj");
        check("wj_pc", 32'(instr_pc), 32'h1234);
        check("wj_data", instr_data, word_at(24'h1234));

        step();
        t = txn_cnt;
        jump_addr = 22'h3FFFFC;
        jump = 1'b1;
        step();
        jump = 1'b0;
        wait_txn(t, "wtxn");
        check("wrap_addr", 32'(f_addr), 32'h3FFFFC);
        wait_valid("ww");
        check("wrap_pc", 32'(instr_pc), 32'h3FFFFC);
        check("wrap_data", instr_data, word_at(24'h3FFFFC));
        check("wrap_select", 32'(spi_select), 32'd1);
        t = txn_cnt;
        wait_txn(t, "w0txn");
        check("wrap_restart_addr", 32'(f_addr), 32'h0);
        wait_valid("wz");
        check("wz_pc", 32'(instr_pc), 32'h0);
        check("wz_data", instr_data, 32'h0000_0513);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
